// File: rtl/alu_sequencer.sv
// Calculator token sequencer: folds (operand, op) tokens into a running accumulator through an
// external ALU and emits the chain result when an equals token (OP_NONE) arrives.

package calc_pkg;
    typedef struct packed {
        logic               error;
        logic signed [15:0] value;
    } num_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_t;
endpackage

module alu_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  num_t tok_num_i,
    input  op_t  tok_op_i,
    input  logic tok_valid_i,
    output logic tok_ready_o,
    output num_t alu_left_o,
    output num_t alu_right_o,
    output op_t  alu_op_o,
    output logic alu_valid_o,
    input  logic alu_ready_i,
    input  num_t alu_result_i,
    input  logic alu_valid_i,
    output logic alu_ready_o,
    output num_t res_o,
    output logic res_valid_o,
    input  logic res_ready_i,
    output logic busy_o
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_PEND,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    typedef struct packed {
        logic tok_ready;
        logic alu_valid;
        logic alu_ready;
        logic res_valid;
        logic busy;
    } flags_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    flags_t           flags;
    num_t             acc;
    num_t             opnd;
    op_t              pend;
    op_t              next_op;
    logic [CNT_W-1:0] tmo_cnt;

    // Handshake outputs are registered copies of the decode of the state being entered.
    function automatic flags_t decode(input state_t s);
        flags_t f;
        f           = '0;
        f.busy      = (s != S_EMPTY);
        f.tok_ready = (s == S_EMPTY) || (s == S_PEND);
        f.alu_valid = (s == S_ISSUE);
        f.alu_ready = (s == S_WAIT);
        f.res_valid = (s == S_EMIT);
        return f;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_EMPTY;
            flags   <= '0;
            acc     <= '0;
            opnd    <= '0;
            pend    <= OP_NONE;
            next_op <= OP_NONE;
            tmo_cnt <= '0;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    flags <= decode(S_EMPTY);
                    if (tok_valid_i && flags.tok_ready) begin
                        acc <= tok_num_i;
                        if (tok_op_i == OP_NONE) begin
                            state <= S_EMIT;
                            flags <= decode(S_EMIT);
                        end else begin
                            pend  <= tok_op_i;
                            state <= S_PEND;
                            flags <= decode(S_PEND);
                        end
                    end
                end
                S_PEND: begin
                    if (tok_valid_i && flags.tok_ready) begin
                        opnd    <= tok_num_i;
                        next_op <= tok_op_i;
                        state   <= S_ISSUE;
                        flags   <= decode(S_ISSUE);
                    end
                end
                S_ISSUE: begin
                    if (alu_ready_i) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                        flags   <= decode(S_WAIT);
                    end
                end
                S_WAIT: begin
                    // A result arriving on the terminal-count cycle takes priority over the timeout.
                    if (alu_valid_i) begin
                        acc     <= alu_result_i;
                        tmo_cnt <= '0;
                        if (alu_result_i.error || (next_op == OP_NONE)) begin
                            state <= S_EMIT;
                            flags <= decode(S_EMIT);
                        end else begin
                            pend  <= next_op;
                            state <= S_PEND;
                            flags <= decode(S_PEND);
                        end
                    end else if (tmo_cnt == CNT_LAST) begin
                        acc     <= '{error: 1'b1, value: '0};
                        tmo_cnt <= '0;
                        state   <= S_EMIT;
                        flags   <= decode(S_EMIT);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready_i) begin
                        pend  <= OP_NONE;
                        state <= S_EMPTY;
                        flags <= decode(S_EMPTY);
                    end
                end
                default: begin
                    state <= S_EMPTY;
                    flags <= decode(S_EMPTY);
                end
            endcase
        end
    end

    assign tok_ready_o = flags.tok_ready;
    assign alu_valid_o = flags.alu_valid;
    assign alu_ready_o = flags.alu_ready;
    assign res_valid_o = flags.res_valid;
    assign busy_o      = flags.busy;
    assign alu_left_o  = acc;
    assign alu_right_o = opnd;
    assign alu_op_o    = pend;
    assign res_o       = acc;

endmodule
